// File: rtl/adc_capture_sequencer.sv
// -----------------------------------------------------------------------------
// adc_capture_sequencer
//
// Capture controller for the ADC front end.
// - Arms on command and synchronises the external SynchrM trigger.
// - On a trigger edge while armed, de-interleaves the one-sample-per-clock ADC
//   stream round-robin across LANES RAM banks, each DEPTH words deep.
// - When the buffer is full, replays it in capture order over a valid/ready
//   stream.
//
// Ports
//   ClockFromADC  in   sole clock, rising edge
//   Reset         in   synchronous, active-high
//   SynchrM       in   asynchronous trigger, rising edge starts capture
//   Arm           in   one-clock pulse: IDLE -> ARMED, clears Overrun
//   Continuous    in   1 = re-arm after readout, 0 = back to IDLE
//   Data          in   ADC sample, valid every clock
//   WriteEnable   out  one-hot bank write strobe
//   AddrWrite     out  write address shared by all banks
//   WriteData     out  converted sample
//   ReadEnable    out  one-hot bank read strobe
//   AddrRead      out  read address
//   RamData       in   bank read data, bank k at [k*DATA_W +: DATA_W]
//   DataOut       out  replayed sample
//   DataValid     out  DataOut is valid
//   DataReady     in   consumer accepts DataOut
//   BuffOn        out  one-clock pulse when capture completes
//   ReadyBuff     out  high from capture complete until last sample accepted
//   Busy          out  capture or readout in progress
//   Overrun       out  sticky: trigger edge seen while capturing/reading out
// -----------------------------------------------------------------------------
module adc_capture_sequencer #(
    parameter int DATA_W    = 14,
    parameter int LANES     = 2,
    parameter int DEPTH     = 2176,
    parameter int ADDR_W    = 12,
    parameter int RAM_LAT   = 1,
    parameter int TWOS_COMP = 1
) (
    input  logic                    ClockFromADC,
    input  logic                    Reset,
    input  logic                    SynchrM,
    input  logic                    Arm,
    input  logic                    Continuous,
    input  logic [DATA_W-1:0]       Data,
    output logic [LANES-1:0]        WriteEnable,
    output logic [ADDR_W-1:0]       AddrWrite,
    output logic [DATA_W-1:0]       WriteData,
    output logic [LANES-1:0]        ReadEnable,
    output logic [ADDR_W-1:0]       AddrRead,
    input  logic [LANES*DATA_W-1:0] RamData,
    output logic [DATA_W-1:0]       DataOut,
    output logic                    DataValid,
    input  logic                    DataReady,
    output logic                    BuffOn,
    output logic                    ReadyBuff,
    output logic                    Busy,
    output logic                    Overrun
);

    localparam int TOTAL  = LANES * DEPTH;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WAIT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  TOTAL_CNT  = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(TOTAL - 1);
    localparam logic [WAIT_W-1:0] WAIT_START = WAIT_W'(RAM_LAT - 1);

    // Readout is split into ISSUE / WAIT / PRESENT sub-steps per sample.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARMED      = 3'd1,
        ST_CAPTURE    = 3'd2,
        ST_RD_ISSUE   = 3'd3,
        ST_RD_WAIT    = 3'd4,
        ST_RD_PRESENT = 3'd5
    } state_t;

    state_t              state_r;

    logic                sync1_r;
    logic                sync2_r;
    logic                sync3_r;
    logic                trig_s;

    logic [LANE_W-1:0]   wrLane_r;
    logic [ADDR_W-1:0]   wrRow_r;
    logic [CNT_W-1:0]    wrCount_r;
    logic [LANE_W-1:0]   nextWrLane_s;
    logic [ADDR_W-1:0]   nextWrRow_s;

    logic [LANE_W-1:0]   rdLane_r;
    logic [ADDR_W-1:0]   rdRow_r;
    logic [CNT_W-1:0]    rdCount_r;
    logic [LANE_W-1:0]   nextRdLane_s;
    logic [ADDR_W-1:0]   nextRdRow_s;
    logic [WAIT_W-1:0]   waitCnt_r;

    logic                inReadout_s;
    logic                captureSample_s;
    logic                captureDone_s;
    logic [DATA_W-1:0]   ramSlice_s;

    // One-hot bank strobe for a lane index.
    function automatic logic [LANES-1:0] laneOneHot(input logic [LANE_W-1:0] lane);
        logic [LANES-1:0] oh;
        oh    = '0;
        oh[0] = 1'b1;
        return oh << lane;
    endfunction

    // Offset-binary to two's complement is a flip of the sign bit.
    function automatic logic [DATA_W-1:0] convertSample(input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] res;
        res = raw;
        if (TWOS_COMP != 0) begin
            res[DATA_W-1] = ~raw[DATA_W-1];
        end else begin
            res = raw;
        end
        return res;
    endfunction

    // Trigger synchroniser plus history flop for rising-edge detection.
    always_ff @(posedge ClockFromADC) begin
        if (Reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= SynchrM;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign trig_s = sync2_r & ~sync3_r;

    // Decode of the current state into the qualifiers used below.
    always_comb begin
        inReadout_s     = 1'b0;
        captureSample_s = 1'b0;
        captureDone_s   = 1'b0;
        case (state_r)
            ST_ARMED: begin
                captureSample_s = trig_s;
            end
            ST_CAPTURE: begin
                captureDone_s   = (wrCount_r == TOTAL_CNT);
                captureSample_s = (wrCount_r != TOTAL_CNT);
            end
            ST_RD_ISSUE, ST_RD_WAIT, ST_RD_PRESENT: begin
                inReadout_s = 1'b1;
            end
            default: begin
                inReadout_s     = 1'b0;
                captureSample_s = 1'b0;
                captureDone_s   = 1'b0;
            end
        endcase
    end

    // Lane-fastest increment of the write position.
    always_comb begin
        nextWrLane_s = wrLane_r;
        nextWrRow_s  = wrRow_r;
        if (wrLane_r == LAST_LANE) begin
            nextWrLane_s = '0;
            nextWrRow_s  = wrRow_r + ADDR_W'(1);
        end else begin
            nextWrLane_s = wrLane_r + LANE_W'(1);
            nextWrRow_s  = wrRow_r;
        end
    end

    // Lane-fastest increment of the read position (same order as capture).
    always_comb begin
        nextRdLane_s = rdLane_r;
        nextRdRow_s  = rdRow_r;
        if (rdLane_r == LAST_LANE) begin
            nextRdLane_s = '0;
            nextRdRow_s  = rdRow_r + ADDR_W'(1);
        end else begin
            nextRdLane_s = rdLane_r + LANE_W'(1);
            nextRdRow_s  = rdRow_r;
        end
    end

    // Read data of the bank currently being replayed.
    always_comb begin
        ramSlice_s = RamData[rdLane_r*DATA_W +: DATA_W];
    end

    // Write datapath: one sample per clock while capturing.
    always_ff @(posedge ClockFromADC) begin
        if (Reset) begin
            WriteEnable <= '0;
            AddrWrite   <= '0;
            WriteData   <= '0;
            wrLane_r    <= '0;
            wrRow_r     <= '0;
            wrCount_r   <= '0;
        end else if (captureSample_s) begin
            WriteEnable <= laneOneHot(wrLane_r);
            AddrWrite   <= wrRow_r;
            WriteData   <= convertSample(Data);
            wrLane_r    <= nextWrLane_s;
            wrRow_r     <= nextWrRow_s;
            wrCount_r   <= wrCount_r + CNT_W'(1);
        end else begin
            WriteEnable <= '0;
            // Counters rewind once capture is over so the next trigger
            // starts again at lane 0, row 0.
            if (state_r != ST_CAPTURE) begin
                wrLane_r  <= '0;
                wrRow_r   <= '0;
                wrCount_r <= '0;
            end
        end
    end

    // Control FSM, readout datapath and status flags.
    always_ff @(posedge ClockFromADC) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            ReadEnable <= '0;
            AddrRead   <= '0;
            DataOut    <= '0;
            DataValid  <= 1'b0;
            BuffOn     <= 1'b0;
            ReadyBuff  <= 1'b0;
            Busy       <= 1'b0;
            Overrun    <= 1'b0;
            rdLane_r   <= '0;
            rdRow_r    <= '0;
            rdCount_r  <= '0;
            waitCnt_r  <= '0;
        end else begin
            BuffOn <= 1'b0;

            // A trigger while busy is flagged but otherwise ignored; it
            // takes precedence over a simultaneous clearing Arm.
            if (trig_s && ((state_r == ST_CAPTURE) || inReadout_s)) begin
                Overrun <= 1'b1;
            end else if (Arm) begin
                Overrun <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (Arm) begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Sample 0 is written by the datapath on this same edge.
                    if (trig_s) begin
                        state_r <= ST_CAPTURE;
                        Busy    <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (captureDone_s) begin
                        state_r    <= ST_RD_ISSUE;
                        BuffOn     <= 1'b1;
                        ReadyBuff  <= 1'b1;
                        ReadEnable <= laneOneHot('0);
                        AddrRead   <= '0;
                        rdLane_r   <= '0;
                        rdRow_r    <= '0;
                        rdCount_r  <= '0;
                    end
                end
                ST_RD_ISSUE: begin
                    ReadEnable <= '0;
                    waitCnt_r  <= WAIT_START;
                    state_r    <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (waitCnt_r == '0) begin
                        DataOut   <= ramSlice_s;
                        DataValid <= 1'b1;
                        state_r   <= ST_RD_PRESENT;
                    end else begin
                        waitCnt_r <= waitCnt_r - WAIT_W'(1);
                    end
                end
                ST_RD_PRESENT: begin
                    if (DataReady) begin
                        DataValid <= 1'b0;
                        if (rdCount_r == LAST_CNT) begin
                            ReadyBuff <= 1'b0;
                            Busy      <= 1'b0;
                            state_r   <= Continuous ? ST_ARMED : ST_IDLE;
                        end else begin
                            // Accept edge doubles as the next ISSUE edge.
                            ReadEnable <= laneOneHot(nextRdLane_s);
                            AddrRead   <= nextRdRow_s;
                            rdLane_r   <= nextRdLane_s;
                            rdRow_r    <= nextRdRow_s;
                            rdCount_r  <= rdCount_r + CNT_W'(1);
                            state_r    <= ST_RD_ISSUE;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ReadEnable <= '0;
                    DataValid  <= 1'b0;
                    ReadyBuff  <= 1'b0;
                    Busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_capture_sequencer
//
// Self-checking bench for adc_capture_sequencer with LANES=2, DEPTH=8,
// RAM_LAT=1, TWOS_COMP=1. A behavioural RAM model sits between the write and
// read ports. Expected writes and replay order are derived from the recorded
// input stream and the trigger time; readout uses random or toggling
// backpressure.
// -----------------------------------------------------------------------------
module tb_adc_capture_sequencer;

    localparam int DATA_W = 14;
    localparam int LANES  = 2;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 12;
    localparam int TOTAL  = LANES * DEPTH;

    logic                    clk = 1'b0;
    logic                    Reset;
    logic                    SynchrM;
    logic                    Arm;
    logic                    Continuous;
    logic [DATA_W-1:0]       Data;
    logic [LANES-1:0]        WriteEnable;
    logic [ADDR_W-1:0]       AddrWrite;
    logic [DATA_W-1:0]       WriteData;
    logic [LANES-1:0]        ReadEnable;
    logic [ADDR_W-1:0]       AddrRead;
    logic [LANES*DATA_W-1:0] RamData;
    logic [DATA_W-1:0]       DataOut;
    logic                    DataValid;
    logic                    DataReady;
    logic                    BuffOn;
    logic                    ReadyBuff;
    logic                    Busy;
    logic                    Overrun;

    adc_capture_sequencer #(
        .DATA_W    (DATA_W),
        .LANES     (LANES),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .RAM_LAT   (1),
        .TWOS_COMP (1)
    ) dut (
        .ClockFromADC (clk),
        .Reset        (Reset),
        .SynchrM      (SynchrM),
        .Arm          (Arm),
        .Continuous   (Continuous),
        .Data         (Data),
        .WriteEnable  (WriteEnable),
        .AddrWrite    (AddrWrite),
        .WriteData    (WriteData),
        .ReadEnable   (ReadEnable),
        .AddrRead     (AddrRead),
        .RamData      (RamData),
        .DataOut      (DataOut),
        .DataValid    (DataValid),
        .DataReady    (DataReady),
        .BuffOn       (BuffOn),
        .ReadyBuff    (ReadyBuff),
        .Busy         (Busy),
        .Overrun      (Overrun)
    );

    always #5 clk = ~clk;

    // Behavioural RAM banks with one clock read latency.
    logic [DATA_W-1:0] mem [0:LANES-1][0:DEPTH-1];
    always @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (WriteEnable[k]) mem[k][AddrWrite[2:0]] <= WriteData;
            if (ReadEnable[k])  RamData[k*DATA_W +: DATA_W] <= mem[k][AddrRead[2:0]];
        end
    end

    typedef struct {
        int                cyc;
        logic [LANES-1:0]  we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               obsW[$];
    logic [DATA_W-1:0] acc[$];
    logic [DATA_W-1:0] expBuf [0:TOTAL-1];
    logic [DATA_W-1:0] dataHist [0:4095];

    int   assertCount = 0;
    int   failCount   = 0;
    int   cyc         = 0;
    int   buffOnCount = 0;
    int   buffOnCyc   = -1;
    int   firstValidCyc = -1;
    int   dataBase    = 0;
    int   readyMode   = 0;
    bit   dataMode    = 1'b0;
    bit   prevStall   = 1'b0;
    logic [DATA_W-1:0] prevOut = '0;
    logic lastAccRB   = 1'b0;
    int   trigAt;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference conversion: offset-binary to two's complement for 14 bits.
    function automatic logic [DATA_W-1:0] refConv(input logic [DATA_W-1:0] x);
        return x ^ 14'h2000;
    endfunction

    // One clock: observe outputs at the falling edge, then drive inputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if ((|WriteEnable) === 1'b1) obsW.push_back('{cyc, WriteEnable, AddrWrite, WriteData});
        if (BuffOn === 1'b1) begin
            buffOnCount++;
            buffOnCyc = cyc;
        end
        if (DataValid === 1'b1 && firstValidCyc < 0) firstValidCyc = cyc;
        if (prevStall && !Reset) begin
            checkEq("holdValid", 32'(DataValid), 32'd1);
            checkEq("holdData", 32'(DataOut), 32'(prevOut));
        end
        case (readyMode)
            0:       DataReady = 1'b1;
            1:       DataReady = ~DataReady;
            default: DataReady = 1'($urandom_range(0, 1));
        endcase
        if (DataValid === 1'b1 && DataReady) begin
            acc.push_back(DataOut);
            if (acc.size() == TOTAL) lastAccRB = ReadyBuff;
        end
        prevStall = (DataValid === 1'b1) && !DataReady;
        prevOut   = DataOut;
        if (dataMode) Data = 14'h2000 + 14'(cyc - dataBase);
        else          Data = 14'($urandom);
        dataHist[cyc % 4096] = Data;
    endtask

    task automatic pulseArm();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
    endtask

    task automatic checkResetValues(input string pfx);
        checkEq({pfx, "_we"},    32'(WriteEnable), 32'd0);
        checkEq({pfx, "_re"},    32'(ReadEnable),  32'd0);
        checkEq({pfx, "_aw"},    32'(AddrWrite),   32'd0);
        checkEq({pfx, "_ar"},    32'(AddrRead),    32'd0);
        checkEq({pfx, "_wd"},    32'(WriteData),   32'd0);
        checkEq({pfx, "_dout"},  32'(DataOut),     32'd0);
        checkEq({pfx, "_valid"}, 32'(DataValid),   32'd0);
        checkEq({pfx, "_buffOn"},32'(BuffOn),      32'd0);
        checkEq({pfx, "_rdyBuf"},32'(ReadyBuff),   32'd0);
        checkEq({pfx, "_busy"},  32'(Busy),        32'd0);
        checkEq({pfx, "_ovr"},   32'(Overrun),     32'd0);
    endtask

    // Trigger a capture from ARMED and check all 16 writes and BuffOn.
    // ovAt > 0 injects a second trigger edge that many clocks later.
    task automatic captureRoutine(input int ovAt, output int t);
        obsW.delete();
        acc.delete();
        buffOnCount   = 0;
        buffOnCyc     = -1;
        firstValidCyc = -1;
        lastAccRB     = 1'b0;
        t        = cyc;
        dataBase = cyc + 2;
        SynchrM  = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            tick();
            if (i == 3) begin
                SynchrM = 1'b0;
                checkEq("busyInCapture", 32'(Busy), 32'd1);
                checkEq("firstWriteLane", 32'(WriteEnable), 32'd1);
            end
            if (ovAt > 0 && i == ovAt)     SynchrM = 1'b1;
            if (ovAt > 0 && i == ovAt + 2) SynchrM = 1'b0;
        end
        checkEq("writeCount", obsW.size(), TOTAL);
        for (int k = 0; k < TOTAL && k < obsW.size(); k++) begin
            checkEq("wrCycle", obsW[k].cyc, t + 3 + k);
            checkEq("wrLane",  32'(obsW[k].we), (k % 2 == 0) ? 32'd1 : 32'd2);
            checkEq("wrAddr",  32'(obsW[k].addr), k / 2);
            checkEq("wrData",  32'(obsW[k].data), 32'(refConv(dataHist[(t + 2 + k) % 4096])));
        end
        checkEq("buffOnCount", buffOnCount, 1);
        checkEq("buffOnCycle", buffOnCyc, t + 3 + TOTAL);
        for (int k = 0; k < TOTAL; k++) expBuf[k] = refConv(dataHist[(t + 2 + k) % 4096]);
    endtask

    // Drain the replay and check order, latency and end-of-buffer flags.
    task automatic waitReplay();
        int n = 0;
        while (acc.size() < TOTAL && n < 400) begin
            tick();
            n++;
        end
        checkEq("replayDone", acc.size(), TOTAL);
        for (int k = 0; k < TOTAL && k < acc.size(); k++)
            checkEq("replayData", 32'(acc[k]), 32'(expBuf[k]));
        checkEq("firstValidLatency", firstValidCyc, buffOnCyc + 2);
        checkEq("readyBuffBeforeLast", 32'(lastAccRB), 32'd1);
        tick();
        checkEq("readyBuffAfter", 32'(ReadyBuff), 32'd0);
        checkEq("validAfter",     32'(DataValid), 32'd0);
        checkEq("busyAfter",      32'(Busy),      32'd0);
    endtask

    initial begin
        Reset      = 1'b1;
        SynchrM    = 1'b0;
        Arm        = 1'b0;
        Continuous = 1'b0;
        Data       = '0;
        DataReady  = 1'b0;

        // Reset state
        tick();
        checkResetValues("reset");
        tick();
        Reset = 1'b0;
        tick();

        // Basic capture with ramp data, replay with toggling backpressure
        dataMode  = 1'b1;
        readyMode = 1;
        pulseArm();
        tick();
        captureRoutine(0, trigAt);
        if (obsW.size() == TOTAL) begin
            checkEq("rampFirst", 32'(obsW[0].data), 32'd0);
            checkEq("rampLast",  32'(obsW[TOTAL-1].data), 32'd15);
        end
        waitReplay();

        // Unarmed trigger: controller must be back in IDLE
        obsW.delete();
        buffOnCount = 0;
        SynchrM = 1'b1;
        repeat (3) tick();
        SynchrM = 1'b0;
        repeat (25) tick();
        checkEq("unarmedWrites",  obsW.size(), 0);
        checkEq("unarmedOverrun", 32'(Overrun), 32'd0);
        checkEq("unarmedBusy",    32'(Busy), 32'd0);
        checkEq("unarmedBuffOn",  buffOnCount, 0);

        // Continuous mode: two captures with a single Arm
        dataMode   = 1'b0;
        readyMode  = 2;
        Continuous = 1'b1;
        pulseArm();
        tick();
        captureRoutine(0, trigAt);
        waitReplay();
        repeat (3) tick();
        captureRoutine(0, trigAt);
        Continuous = 1'b0;
        waitReplay();

        // Overrun: second trigger edge in the middle of a capture
        readyMode = 0;
        pulseArm();
        tick();
        captureRoutine(8, trigAt);
        checkEq("overrunSet", 32'(Overrun), 32'd1);
        waitReplay();
        checkEq("overrunSticky", 32'(Overrun), 32'd1);
        pulseArm();
        checkEq("overrunCleared", 32'(Overrun), 32'd0);

        // Reset after five writes (controller is ARMED from the Arm above)
        tick();
        obsW.delete();
        buffOnCount = 0;
        SynchrM = 1'b1;
        repeat (3) tick();
        SynchrM = 1'b0;
        repeat (4) tick();
        checkEq("writesBeforeReset", obsW.size(), 5);
        Reset = 1'b1;
        tick();
        checkResetValues("midReset");
        Reset = 1'b0;
        repeat (30) tick();
        checkEq("noBuffOnAfterReset", buffOnCount, 0);
        checkEq("noWritesAfterReset", obsW.size(), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
